// File: rtl/fwnoc_link_pkg.sv
// Shared types and constants for the off-chip NoC link arbiter.
// Channel ids match the link_chan encoding; NOC_LEN_* locate the header payload-length field.
package fwnoc_link_pkg;

    localparam int NUM_CHAN    = 3;
    localparam int NOC_LEN_MSB = 29;
    localparam int NOC_LEN_LSB = 22;
    localparam int NOC_LEN_W   = NOC_LEN_MSB - NOC_LEN_LSB + 1;

    typedef enum logic [1:0] {
        CHAN_NOC1 = 2'd0,
        CHAN_NOC2 = 2'd1,
        CHAN_NOC3 = 2'd2
    } chan_id_t;

    // Round-robin successor; channel id 3 is never produced.
    function automatic chan_id_t chan_next(input chan_id_t c);
        case (c)
            CHAN_NOC1: return CHAN_NOC2;
            CHAN_NOC2: return CHAN_NOC3;
            default:   return CHAN_NOC1;
        endcase
    endfunction

endpackage

// File: rtl/fwnoc_link_if.sv
// Bundles the three credit-based input channels and the merged off-chip link.
// slave = arbiter side, master = chip/bridge side driving flits and link credits.
interface fwnoc_link_if #(
    parameter int DATA_WIDTH = 64
);
    import fwnoc_link_pkg::*;

    logic [NUM_CHAN-1:0]            in_valid;
    logic [NUM_CHAN*DATA_WIDTH-1:0] in_data;
    logic [NUM_CHAN-1:0]            in_yummy;
    logic                           link_valid;
    logic [1:0]                     link_chan;
    logic [DATA_WIDTH-1:0]          link_data;
    logic [NUM_CHAN-1:0]            link_yummy;
    logic [NUM_CHAN-1:0]            err_overflow;

    modport master (
        output in_valid, in_data, link_yummy,
        input  in_yummy, link_valid, link_chan, link_data, err_overflow
    );

    modport slave (
        input  in_valid, in_data, link_yummy,
        output in_yummy, link_valid, link_chan, link_data, err_overflow
    );

endinterface

// File: rtl/fwnoc_link_fifo.sv
// Synchronous per-channel input FIFO with combinational head view.
// A pop on a full FIFO frees the slot for a push on the same edge; pops on empty are ignored.
module fwnoc_link_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW:0]      count_reg;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr_reg];

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= (wr_ptr_reg == AW'(DEPTH - 1)) ? '0 : wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= (rd_ptr_reg == AW'(DEPTH - 1)) ? '0 : rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/fwnoc_link_arb.sv
// Merges noc1/noc2/noc3 onto one off-chip link: input FIFOs, yummy return, downstream credits, RR grant.
// Define FWNOC_LINK_PKT_LOCK_EN to hold the grant on one channel for a whole multi-flit packet.
module fwnoc_link_arb
    import fwnoc_link_pkg::*;
#(
    parameter int DATA_WIDTH  = 64,
    parameter int IN_DEPTH    = 4,
    parameter int OUT_CREDITS = 8
) (
    input logic         clock,
    input logic         rst_n,
    fwnoc_link_if.slave bus
);

    localparam int CW = $clog2(OUT_CREDITS + 1);

    logic [NUM_CHAN-1:0]   fifo_full;
    logic [NUM_CHAN-1:0]   fifo_empty;
    logic [NUM_CHAN-1:0]   eligible;
    logic [NUM_CHAN-1:0]   pop;
    logic [DATA_WIDTH-1:0] head [NUM_CHAN];
    logic [CW-1:0]         credit_reg [NUM_CHAN];
    logic [NUM_CHAN-1:0]   in_yummy_reg;
    logic [NUM_CHAN-1:0]   err_overflow_reg;
    logic                  link_valid_reg;
    logic [1:0]            link_chan_reg;
    logic [DATA_WIDTH-1:0] link_data_reg;
    chan_id_t              rr_ptr_reg;
    chan_id_t              grant_chan;
    logic                  grant_valid;

`ifdef FWNOC_LINK_PKT_LOCK_EN
    logic                 lock_active_reg;
    chan_id_t             lock_chan_reg;
    logic [NOC_LEN_W-1:0] remain_reg;
    logic [NOC_LEN_W-1:0] head_len;
`endif

    generate
        for (genvar gi = 0; gi < NUM_CHAN; gi++) begin : g_chan
            fwnoc_link_fifo #(
                .DEPTH (IN_DEPTH),
                .WIDTH (DATA_WIDTH)
            ) u_fifo (
                .clock     (clock),
                .rst_n     (rst_n),
                .push      (bus.in_valid[gi]),
                .push_data (bus.in_data[gi*DATA_WIDTH +: DATA_WIDTH]),
                .pop       (pop[gi]),
                .full      (fifo_full[gi]),
                .empty     (fifo_empty[gi]),
                .head      (head[gi])
            );
            assign eligible[gi] = !fifo_empty[gi] && (credit_reg[gi] != '0);
        end
    endgenerate

    always_comb begin
        chan_id_t cand;
        grant_valid = 1'b0;
        grant_chan  = rr_ptr_reg;
        cand        = rr_ptr_reg;
        for (int k = 0; k < NUM_CHAN; k++) begin
            if (!grant_valid && eligible[cand]) begin
                grant_valid = 1'b1;
                grant_chan  = cand;
            end
            cand = chan_next(cand);
        end
`ifdef FWNOC_LINK_PKT_LOCK_EN
        // A locked channel stalls the link rather than yielding it.
        if (lock_active_reg) begin
            grant_chan  = lock_chan_reg;
            grant_valid = eligible[lock_chan_reg];
        end
`endif
    end

    assign pop = grant_valid ? (NUM_CHAN'(1) << grant_chan) : '0;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            link_valid_reg   <= 1'b0;
            link_chan_reg    <= 2'd0;
            link_data_reg    <= '0;
            rr_ptr_reg       <= CHAN_NOC1;
            in_yummy_reg     <= '0;
            err_overflow_reg <= '0;
            for (int i = 0; i < NUM_CHAN; i++) begin
                credit_reg[i] <= CW'(OUT_CREDITS);
            end
        end else begin
            link_valid_reg <= grant_valid;
            if (grant_valid) begin
                link_chan_reg <= grant_chan;
                link_data_reg <= head[grant_chan];
                rr_ptr_reg    <= chan_next(grant_chan);
            end
            in_yummy_reg <= pop;
            for (int i = 0; i < NUM_CHAN; i++) begin
                // Only a flit actually dropped counts as overflow; a same-edge pop makes room.
                if (bus.in_valid[i] && fifo_full[i] && !pop[i]) begin
                    err_overflow_reg[i] <= 1'b1;
                end
                case ({pop[i], bus.link_yummy[i]})
                    2'b10: credit_reg[i] <= credit_reg[i] - 1'b1;
                    2'b01: if (credit_reg[i] != CW'(OUT_CREDITS)) credit_reg[i] <= credit_reg[i] + 1'b1;
                    default: credit_reg[i] <= credit_reg[i];
                endcase
            end
        end
    end

`ifdef FWNOC_LINK_PKT_LOCK_EN
    assign head_len = head[grant_chan][NOC_LEN_MSB:NOC_LEN_LSB];

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            lock_active_reg <= 1'b0;
            lock_chan_reg   <= CHAN_NOC1;
            remain_reg      <= '0;
        end else if (grant_valid) begin
            if (lock_active_reg) begin
                remain_reg <= remain_reg - 1'b1;
                if (remain_reg == NOC_LEN_W'(1)) begin
                    lock_active_reg <= 1'b0;
                end
            end else if (head_len != '0) begin
                lock_active_reg <= 1'b1;
                lock_chan_reg   <= grant_chan;
                remain_reg      <= head_len;
            end
        end
    end
`endif

    assign bus.link_valid   = link_valid_reg;
    assign bus.link_chan    = link_chan_reg;
    assign bus.link_data    = link_data_reg;
    assign bus.in_yummy     = in_yummy_reg;
    assign bus.err_overflow = err_overflow_reg;

endmodule
